// File: rtl/xor_crypt_seq.sv
// xor_crypt_seq: sequences the accumulator ALU, RAM and shared sysbus to
// XOR-encrypt/decrypt a block of memory words, optionally complementing each
// result and rotating the key between words. Counts result words equal to 0.
module xor_crypt_seq #(
    parameter int WORD_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic [WORD_W-1:0] key,
    input  logic              rotate_en,
    input  logic              comp_en,
    input  logic              z_flag,
    inout  wire  [WORD_W-1:0] sysbus,
    output logic              ACC_bus,
    output logic              load_ACC,
    output logic              ALU_ACC,
    output logic              ALU_xor,
    output logic              ALU_comp,
    output logic              ALU_add,
    output logic              ALU_sub,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] zero_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_XOR   = 3'd2,
        ST_COMP  = 3'd3,
        ST_STORE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [WORD_W-1:0] WORD_ZERO = {WORD_W{1'b0}};

    // Key rotation applied between words when rotate_en was captured.
    function automatic logic [WORD_W-1:0] rotl1(input logic [WORD_W-1:0] v);
        rotl1 = {v[WORD_W-2:0], v[WORD_W-1]};
    endfunction

    state_t            state_r;
    state_t            state_n;
    logic [ADDR_W-1:0] src_r;
    logic [ADDR_W-1:0] dst_r;
    logic [ADDR_W-1:0] len_r;
    logic [ADDR_W-1:0] idx_r;
    logic [ADDR_W-1:0] zero_cnt_r;
    logic [WORD_W-1:0] key_r;
    logic              rot_en_r;
    logic              comp_en_r;

    logic              capture_s;
    logic              advance_s;
    logic              rotate_s;
    logic              key_drive_s;

    // The key is the only thing this block ever puts on the shared bus.
    assign sysbus = key_drive_s ? key_r : {WORD_W{1'bz}};

    // Next-state decode and per-state ALU/RAM controls; reset forces everything quiet.
    always_comb begin
        state_n     = state_r;
        capture_s   = 1'b0;
        advance_s   = 1'b0;
        rotate_s    = 1'b0;
        key_drive_s = 1'b0;
        ACC_bus     = 1'b0;
        load_ACC    = 1'b0;
        ALU_ACC     = 1'b0;
        ALU_xor     = 1'b0;
        ALU_comp    = 1'b0;
        ALU_add     = 1'b0;
        ALU_sub     = 1'b0;
        mem_addr    = ADDR_ZERO;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        zero_cnt    = reset ? ADDR_ZERO : zero_cnt_r;
        if (reset) begin
            state_n = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // abort beats a simultaneous start
                    if (start && !abort) begin
                        capture_s = 1'b1;
                        state_n   = (length == ADDR_ZERO) ? ST_DONE : ST_FETCH;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    mem_addr = src_r + idx_r;
                    mem_rd   = 1'b1;
                    load_ACC = 1'b1;
                    busy     = 1'b1;
                    state_n  = abort ? ST_IDLE : ST_XOR;
                end
                ST_XOR: begin
                    key_drive_s = 1'b1;
                    load_ACC    = 1'b1;
                    ALU_ACC     = 1'b1;
                    ALU_xor     = 1'b1;
                    busy        = 1'b1;
                    rotate_s    = rot_en_r;
                    if (abort) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = comp_en_r ? ST_COMP : ST_STORE;
                    end
                end
                ST_COMP: begin
                    load_ACC = 1'b1;
                    ALU_ACC  = 1'b1;
                    ALU_comp = 1'b1;
                    busy     = 1'b1;
                    state_n  = abort ? ST_IDLE : ST_STORE;
                end
                ST_STORE: begin
                    // the write itself is combinational, so it lands even if aborted
                    mem_addr = dst_r + idx_r;
                    ACC_bus  = 1'b1;
                    mem_wr   = 1'b1;
                    busy     = 1'b1;
                    if (abort) begin
                        state_n = ST_IDLE;
                    end else begin
                        advance_s = 1'b1;
                        state_n   = ((idx_r + ADDR_ONE) == len_r) ? ST_DONE : ST_FETCH;
                    end
                end
                ST_DONE: begin
                    done    = 1'b1;
                    state_n = ST_IDLE;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // State, job registers, key rotation, word index and zero-result counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            src_r      <= ADDR_ZERO;
            dst_r      <= ADDR_ZERO;
            len_r      <= ADDR_ZERO;
            idx_r      <= ADDR_ZERO;
            zero_cnt_r <= ADDR_ZERO;
            key_r      <= WORD_ZERO;
            rot_en_r   <= 1'b0;
            comp_en_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            if (capture_s) begin
                src_r      <= src_addr;
                dst_r      <= dst_addr;
                len_r      <= length;
                key_r      <= key;
                rot_en_r   <= rotate_en;
                comp_en_r  <= comp_en;
                idx_r      <= ADDR_ZERO;
                zero_cnt_r <= ADDR_ZERO;
            end else begin
                if (rotate_s) begin
                    key_r <= rotl1(key_r);
                end
                if (advance_s) begin
                    idx_r <= idx_r + ADDR_ONE;
                    if (z_flag) begin
                        zero_cnt_r <= zero_cnt_r + ADDR_ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_xor_crypt_seq.sv
// Directed bench for xor_crypt_seq with a small RAM and accumulator-ALU model
// sharing sysbus with the sequencer.
module tb_xor_crypt_seq;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [4:0] src_addr = 5'd0;
    logic [4:0] dst_addr = 5'd0;
    logic [4:0] length = 5'd0;
    logic [7:0] key = 8'h00;
    logic       rotate_en = 1'b0;
    logic       comp_en = 1'b0;
    logic       z_flag;
    wire  [7:0] sysbus;
    logic       ACC_bus, load_ACC, ALU_ACC, ALU_xor, ALU_comp, ALU_add, ALU_sub;
    logic [4:0] mem_addr;
    logic       mem_rd, mem_wr, busy, done;
    logic [4:0] zero_cnt;

    logic [7:0] mem [0:31];
    logic [7:0] acc_r = 8'h00;
    logic       tb_wr_en = 1'b0;
    logic [4:0] tb_wr_addr = 5'd0;
    logic [7:0] tb_wr_data = 8'h00;

    int rd_total = 0;
    int wr_total = 0;
    int done_total = 0;
    int conflict_total = 0;
    int n_tests = 0;
    int n_fail = 0;

    logic [20:0] outs_s;
    assign outs_s = {ACC_bus, load_ACC, ALU_ACC, ALU_xor, ALU_comp, ALU_add, ALU_sub,
                     mem_rd, mem_wr, busy, done, mem_addr, zero_cnt};

    xor_crypt_seq #(.WORD_W(8), .ADDR_W(5)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .key(key),
        .rotate_en(rotate_en), .comp_en(comp_en), .z_flag(z_flag), .sysbus(sysbus),
        .ACC_bus(ACC_bus), .load_ACC(load_ACC), .ALU_ACC(ALU_ACC), .ALU_xor(ALU_xor),
        .ALU_comp(ALU_comp), .ALU_add(ALU_add), .ALU_sub(ALU_sub), .mem_addr(mem_addr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .busy(busy), .done(done), .zero_cnt(zero_cnt)
    );

    always #5 clock = ~clock;

    // RAM and ALU drivers onto the shared bus
    assign sysbus = mem_rd ? mem[mem_addr] : (ACC_bus ? acc_r : 8'bzzzzzzzz);
    assign z_flag = (acc_r == 8'h00);

    // RAM write port: DUT store, or bench preload while the DUT is idle
    always @(posedge clock) begin
        if (mem_wr) mem[mem_addr] <= sysbus;
        else if (tb_wr_en) mem[tb_wr_addr] <= tb_wr_data;
    end

    // Accumulator ALU model
    always @(posedge clock) begin
        if (load_ACC) begin
            if (!ALU_ACC) acc_r <= sysbus;
            else if (ALU_xor) acc_r <= acc_r ^ sysbus;
            else if (ALU_comp) acc_r <= ~acc_r;
        end
    end

    // Activity monitor: bus/memory usage, done pulses and bus driver conflicts
    always @(negedge clock) begin
        rd_total   <= rd_total + int'(mem_rd);
        wr_total   <= wr_total + int'(mem_wr);
        done_total <= done_total + int'(done);
        if ((int'(mem_rd) + int'(ACC_bus) + int'(ALU_xor)) > 1)
            conflict_total <= conflict_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [4:0] a, input logic [7:0] d);
        tb_wr_addr = a;
        tb_wr_data = d;
        tb_wr_en   = 1'b1;
        @(negedge clock);
        tb_wr_en   = 1'b0;
    endtask

    // Launch a job from a negedge and wait (bounded) for done; returns busy
    // cycle count, done cycle (1 = first cycle after start) and rd/wr counts.
    task automatic run_job(input logic [4:0] s, input logic [4:0] d, input logic [4:0] l,
                           input logic [7:0] k, input logic r, input logic c,
                           output int busy_n, output int done_at, output int rd_n, output int wr_n);
        int rd0, wr0;
        rd0 = rd_total;
        wr0 = wr_total;
        src_addr = s; dst_addr = d; length = l; key = k; rotate_en = r; comp_en = c;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        src_addr = 5'd0; dst_addr = 5'd0; length = 5'd0; key = 8'h00;
        busy_n = 0;
        done_at = 0;
        for (int cyc = 1; cyc <= 200 && done_at == 0; cyc++) begin
            if (busy) busy_n++;
            if (done) done_at = cyc;
            if (done_at == 0) @(negedge clock);
        end
        if (done_at == 0) check("done_timeout", 32'd0, 32'd1);
        @(negedge clock);
        rd_n = rd_total - rd0;
        wr_n = wr_total - wr0;
    endtask

    int busy_n, done_at, rd_n, wr_n, done0;

    initial begin
        // reset holds everything quiet, even with start requested
        start = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_outs", 32'(outs_s), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        check("idle_outs", 32'(outs_s), 32'd0);

        // basic job
        poke(5'd0, 8'h00); poke(5'd1, 8'h5A); poke(5'd2, 8'hFF);
        run_job(5'd0, 5'd8, 5'd3, 8'h5A, 1'b0, 1'b0, busy_n, done_at, rd_n, wr_n);
        check("t1_mem8", 32'(mem[8]), 32'h5A);
        check("t1_mem9", 32'(mem[9]), 32'h00);
        check("t1_mem10", 32'(mem[10]), 32'hA5);
        check("t1_busy", 32'(busy_n), 32'd9);
        check("t1_done_at", 32'(done_at), 32'd10);
        check("t1_rd", 32'(rd_n), 32'd3);
        check("t1_wr", 32'(wr_n), 32'd3);
        repeat (3) @(negedge clock);
        check("t1_zero_hold", 32'(zero_cnt), 32'd1);

        // rotating key
        run_job(5'd0, 5'd8, 5'd3, 8'h5A, 1'b1, 1'b0, busy_n, done_at, rd_n, wr_n);
        check("t2_mem8", 32'(mem[8]), 32'h5A);
        check("t2_mem9", 32'(mem[9]), 32'hEE);
        check("t2_mem10", 32'(mem[10]), 32'h96);
        check("t2_zero", 32'(zero_cnt), 32'd0);

        // complement
        poke(5'd0, 8'h0F); poke(5'd16, 8'h77);
        run_job(5'd0, 5'd16, 5'd1, 8'hF0, 1'b0, 1'b1, busy_n, done_at, rd_n, wr_n);
        check("t3_mem16", 32'(mem[16]), 32'h00);
        check("t3_zero", 32'(zero_cnt), 32'd1);
        check("t3_busy", 32'(busy_n), 32'd4);
        check("t3_done_at", 32'(done_at), 32'd5);

        // zero-length job
        run_job(5'd3, 5'd4, 5'd0, 8'h11, 1'b0, 1'b0, busy_n, done_at, rd_n, wr_n);
        check("t4_done_at", 32'(done_at), 32'd1);
        check("t4_busy", 32'(busy_n), 32'd0);
        check("t4_rd", 32'(rd_n), 32'd0);
        check("t4_wr", 32'(wr_n), 32'd0);
        check("t4_zero_cleared", 32'(zero_cnt), 32'd0);

        // in place, wrapping addresses
        poke(5'd30, 8'h11); poke(5'd31, 8'h22); poke(5'd0, 8'h33); poke(5'd1, 8'h44);
        run_job(5'd30, 5'd30, 5'd3, 8'h3C, 1'b0, 1'b0, busy_n, done_at, rd_n, wr_n);
        check("t5_mem30", 32'(mem[30]), 32'h2D);
        check("t5_mem31", 32'(mem[31]), 32'h1E);
        check("t5_mem0", 32'(mem[0]), 32'h0F);
        check("t5_mem1", 32'(mem[1]), 32'h44);
        check("t5_busy", 32'(busy_n), 32'd9);

        // abort in XOR of word 1, with an ignored second start while busy
        poke(5'd0, 8'h01); poke(5'd1, 8'h02); poke(5'd2, 8'h03); poke(5'd3, 8'h04);
        poke(5'd20, 8'hAA); poke(5'd21, 8'hAA);
        done0 = done_total;
        src_addr = 5'd0; dst_addr = 5'd20; length = 5'd4; key = 8'hFF;
        rotate_en = 1'b0; comp_en = 1'b0; start = 1'b1;
        @(negedge clock);                       // cycle 1: FETCH w0
        start = 1'b0;
        check("t6_fetch_rd", 32'(mem_rd), 32'd1);
        @(negedge clock);                       // cycle 2: XOR w0
        start = 1'b1; length = 5'd1;
        @(negedge clock);                       // cycle 3: STORE w0
        start = 1'b0;
        check("t6_store_addr", 32'(mem_addr), 32'd20);
        @(negedge clock);                       // cycle 4: FETCH w1
        @(negedge clock);                       // cycle 5: XOR w1
        check("t6_in_xor", 32'(ALU_xor), 32'd1);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("t6_idle_outs", 32'(outs_s), 32'd0);
        repeat (4) @(negedge clock);
        check("t6_no_done", 32'(done_total - done0), 32'd0);
        check("t6_mem20", 32'(mem[20]), 32'hFE);
        check("t6_mem21", 32'(mem[21]), 32'hAA);
        check("t6_busy", 32'(busy), 32'd0);

        // abort together with start in IDLE
        src_addr = 5'd0; dst_addr = 5'd24; length = 5'd2; key = 8'h01;
        start = 1'b1; abort = 1'b1;
        @(negedge clock);
        start = 1'b0; abort = 1'b0;
        check("t7_no_start", 32'(outs_s), 32'd0);

        // reset mid-job
        src_addr = 5'd0; dst_addr = 5'd8; length = 5'd3; key = 8'h12; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);            // cycle 4: FETCH w1
        check("t8_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("t8_reset_comb", 32'(outs_s), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("t8_after_reset", 32'(outs_s), 32'd0);

        check("bus_exclusive", 32'(conflict_total), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/xor_crypt_seq.md
Name: xor_crypt_seq

Overview:
- Sequencer that drives the accumulator ALU and system bus to XOR-encrypt or decrypt a block of memory words in place or to a second buffer.
- Per word: fetch from source into ACC, XOR ACC with the key driven onto sysbus, optionally complement, write ACC to destination.
- Sits beside the ALU and RAM on the shared sysbus; its ALU control outputs connect to the same-named ALU inputs.

Parameters:
- WORD_W, 8, data/key width; matches ALU and sysbus.
- ADDR_W, 5, memory address, length and counter width.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- abort  input  1  cancel the current job.
- src_addr  input  ADDR_W  first source word address.
- dst_addr  input  ADDR_W  first destination word address.
- length  input  ADDR_W  word count; 0 is legal.
- key  input  WORD_W  initial key.
- rotate_en  input  1  rotate the key left by 1 after each word.
- comp_en  input  1  complement ACC after the XOR.
- z_flag  input  1  ALU zero flag.
- sysbus  inout  WORD_W  shared bus; driven with the key only in XOR, else 'z.
- ACC_bus, load_ACC, ALU_ACC, ALU_xor, ALU_comp, ALU_add, ALU_sub  output  1 each  ALU controls.
- mem_addr  output  ADDR_W  RAM address.
- mem_rd  output  1  RAM drives sysbus combinationally in the same cycle.
- mem_wr  output  1  RAM captures sysbus on the clock edge.
- busy  output  1  job in progress.
- done  output  1  one-cycle completion pulse.
- zero_cnt  output  ADDR_W  count of result words equal to 0.

Behaviour:
- Reset, and any cycle where reset is high:
  - state IDLE; all outputs 0; sysbus 'z; zero_cnt 0; internal registers cleared.
  - Reset overrides start and abort.
- Job capture: start high in IDLE latches src, dst, length, key, rotate_en and comp_en into internal registers, clears zero_cnt and word index i; the next state is FETCH, or DONE if length == 0. Inputs may change after that.
- States: IDLE, FETCH, XOR, COMP, STORE, DONE.
- Per-state outputs (all unlisted outputs 0):
  - FETCH: mem_addr = src+i, mem_rd = 1, load_ACC = 1, ALU_ACC = 0. ACC <= mem word.
  - XOR: sysbus = key_reg, load_ACC = 1, ALU_ACC = 1, ALU_xor = 1. If rotate_en, key_reg rotates left by 1 at the end of the cycle.
  - COMP (only if comp_en): load_ACC = 1, ALU_ACC = 1, ALU_comp = 1.
  - STORE: mem_addr = dst+i, ACC_bus = 1, mem_wr = 1. If z_flag, zero_cnt increments. i increments. Next state is DONE if i+1 == length, else FETCH.
  - DONE: done = 1, busy = 0 for exactly one cycle, then IDLE.
- ALU_add and ALU_sub are held at 0 always.
- busy is high in FETCH, XOR, COMP and STORE.
- Timing:
  - 3 cycles per word, or 4 with comp_en.
  - busy high for 3L (or 4L) cycles starting the cycle after start.
  - done follows immediately.
  - length 0: done high the cycle after start; no bus or memory activity.
- Addresses: src+i and dst+i are computed modulo 2^ADDR_W and wrap silently.
- Bus exclusivity: at most one of mem_rd, ACC_bus or the key driver is active in any cycle.
- start while busy or in DONE: ignored.
- abort:
  - In FETCH, XOR, COMP or STORE: next state IDLE, no done pulse. A STORE that is in progress with abort still completes its write that cycle, because mem_wr is combinational. zero_cnt holds its value.
  - abort in IDLE or DONE: no effect.
  - abort together with start in IDLE: abort wins; no job starts.
- zero_cnt holds after done until the next accepted start or reset.
- length == 2^ADDR_W−1 is the maximum; no overflow of i.

Test Plan:
- src=0, dst=8, L=3, key=0x5A, rotate_en=0, comp_en=0, mem[0..2]=0x00,0x5A,0xFF → mem[8..10]=0x5A,0x00,0xA5; busy for 9 cycles; done in cycle 10; zero_cnt=1.
- Same job with rotate_en=1 → keys used are 0x5A,0xB4,0x69; mem[8..10]=0x5A,0xEE,0x96; zero_cnt=0.
- comp_en=1, L=1, mem[0]=0x0F, key=0xF0 → mem[dst]=0x00; zero_cnt=1; busy for 4 cycles.
- L=0 → done the cycle after start; mem_rd and mem_wr never asserted.
- src=30, dst=30, L=3 (in place, wrapping) → addresses 30,31,0 read and written; mem[30],mem[31],mem[0] each XORed with the key.
- abort asserted in XOR of word 1 of an L=4 job → IDLE next cycle; only word 0 written; no done; a second start during busy is ignored; reset mid-job → IDLE, all outputs 0 the cycle after.
